// File: rtl/alu_uart_ctrl.sv
// Sequences three received bytes (A, B, opcode) into ALU load strobes, then returns the 9-bit result as two tx bytes.
// First tx start appears 3 edges after the opcode byte is accepted; waits indefinitely on rx/tx handshakes (no timeout).
module alu_uart_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_OPS  = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA:0]   i_alu_res,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OPS-1:0]  o_ops,
    output logic [2:0]         o_alu_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND_LO,
        ST_WAIT_LO,
        ST_SEND_HI,
        ST_WAIT_HI
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [NB_DATA-1:0] r_data_a;
    logic [NB_DATA-1:0] r_data_b;
    logic [NB_OPS-1:0]  r_ops;
    logic [2:0]         r_alu_valid;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_tx_start;
    logic               r_busy;
    logic [NB_DATA:0]   r_result;

    logic [NB_DATA-1:0] w_data_a;
    logic [NB_DATA-1:0] w_data_b;
    logic [NB_OPS-1:0]  w_ops;
    logic [2:0]         w_alu_valid;
    logic [NB_DATA-1:0] w_tx_data;
    logic               w_tx_start;
    logic               w_busy;
    logic [NB_DATA:0]   w_result;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_WAIT_A;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_ops       <= '0;
            r_alu_valid <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
        end else begin
            r_state     <= w_next;
            r_data_a    <= w_data_a;
            r_data_b    <= w_data_b;
            r_ops       <= w_ops;
            r_alu_valid <= w_alu_valid;
            r_tx_data   <= w_tx_data;
            r_tx_start  <= w_tx_start;
            r_busy      <= w_busy;
            r_result    <= w_result;
        end
    end

    // Outputs are computed for the state being entered, so every port comes straight from a flop.
    always_comb begin
        w_next      = r_state;
        w_data_a    = r_data_a;
        w_data_b    = r_data_b;
        w_ops       = r_ops;
        w_alu_valid = 3'b000;
        w_tx_data   = r_tx_data;
        w_tx_start  = 1'b0;
        w_result    = r_result;
        unique case (r_state)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    w_data_a    = i_rx_data;
                    w_alu_valid = 3'b001;
                    w_next      = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    w_data_b    = i_rx_data;
                    w_alu_valid = 3'b010;
                    w_next      = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    w_ops       = i_rx_data[NB_OPS-1:0];
                    w_alu_valid = 3'b100;
                    w_next      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_SEND_LO;
            end
            // ALU latches the opcode at the end of EXEC, so its result is only settled here.
            ST_SEND_LO: begin
                w_result   = i_alu_res;
                w_tx_data  = i_alu_res[NB_DATA-1:0];
                w_tx_start = 1'b1;
                w_next     = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (i_tx_done) begin
                    w_next = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                w_tx_data  = {{(NB_DATA-1){1'b0}}, r_result[NB_DATA]};
                w_tx_start = 1'b1;
                w_next     = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (i_tx_done) begin
                    w_next = ST_WAIT_A;
                end
            end
            default: begin
                w_next = ST_WAIT_A;
            end
        endcase
        w_busy = !((w_next == ST_WAIT_A) || (w_next == ST_WAIT_B) || (w_next == ST_WAIT_OP));
    end

    assign o_data_a    = r_data_a;
    assign o_data_b    = r_data_b;
    assign o_ops       = r_ops;
    assign o_alu_valid = r_alu_valid;
    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Bench for alu_uart_ctrl with a behavioural ALU and a uart_tx stand-in returning tx_done 10 cycles after tx_start.
module tb_alu_uart_ctrl;

    localparam int NB_DATA = 8;
    localparam int NB_OPS  = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NB_DATA-1:0] rx_data = '0;
    logic               rx_done = 1'b0;
    logic [NB_DATA:0]   alu_res;
    logic               tx_done = 1'b0;
    logic [NB_DATA-1:0] data_a;
    logic [NB_DATA-1:0] data_b;
    logic [NB_OPS-1:0]  ops;
    logic [2:0]         alu_valid;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_uart_ctrl #(.NB_DATA(NB_DATA), .NB_OPS(NB_OPS)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_alu_res   (alu_res),
        .i_tx_done   (tx_done),
        .o_data_a    (data_a),
        .o_data_b    (data_b),
        .o_ops       (ops),
        .o_alu_valid (alu_valid),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_busy      (busy)
    );

    // Behavioural ALU: latches operands/opcode on their strobes, result combinational.
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic [5:0] m_op = '0;
    always @(posedge clk) begin
        if (alu_valid[0]) m_a <= data_a;
        if (alu_valid[1]) m_b <= data_b;
        if (alu_valid[2]) m_op <= ops;
    end
    always_comb begin
        case (m_op)
            6'h20:   alu_res = {1'b0, m_a} + {1'b0, m_b};
            6'h22:   alu_res = {1'b0, m_a - m_b};
            6'h24:   alu_res = {1'b0, m_a & m_b};
            6'h25:   alu_res = {1'b0, m_a | m_b};
            default: alu_res = '0;
        endcase
    end

    logic start_prev = 1'b0;
    logic start_long = 1'b0;
    always @(negedge clk) begin
        if (tx_start && start_prev) start_long = 1'b1;
        start_prev = tx_start;
    end

    task automatic send_byte(input logic [7:0] d, input logic [2:0] exp_vld);
        @(negedge clk);
        rx_data = d;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        n_cmp++;
        if (alu_valid !== exp_vld) begin
            n_err++;
            $display("FAIL strobe byte=%h: got %b want %b", d, alu_valid, exp_vld);
        end
        @(negedge clk);
        n_cmp++;
        if (alu_valid !== 3'b000) begin
            n_err++;
            $display("FAIL strobe_clear byte=%h: got %b want 000", d, alu_valid);
        end
    endtask

    task automatic wait_start(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (tx_start) ok = 1'b1;
        end
    endtask

    // drop: inject a 0xAA rx byte during WAIT_LO and another coincident with the final tx_done.
    task automatic tx_byte(input bit first, input bit drop, input logic [7:0] exp_a);
        int cyc;
        bit ok;
        logic [7:0] exp;
        wait_start(cyc, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL tx_start_timeout first=%0d: got none want pulse", first);
            return;
        end
        if (first) begin
            n_cmp++;
            if (cyc !== 1) begin
                n_err++;
                $display("FAIL tx_latency: got %0d want 1", cyc);
            end
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_unexpected: got %h want none", tx_data);
        end else begin
            exp = exp_q.pop_front();
            if (tx_data !== exp) begin
                n_err++;
                $display("FAIL tx_data first=%0d: got %h want %h", first, tx_data, exp);
            end
        end
        if (first && drop) begin
            repeat (3) @(negedge clk);
            rx_data = 8'hAA;
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
            n_cmp++;
            if (alu_valid !== 3'b000 || data_a !== exp_a || tx_data !== exp) begin
                n_err++;
                $display("FAIL drop_wait_lo: got vld=%b a=%h tx=%h want vld=000 a=%h tx=%h",
                         alu_valid, data_a, tx_data, exp_a, exp);
            end
            repeat (5) @(negedge clk);
        end else begin
            repeat (9) @(negedge clk);
        end
        tx_done = 1'b1;
        if (!first && drop) begin
            rx_data = 8'hAA;
            rx_done = 1'b1;
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_before_done first=%0d: got %b want 1", first, busy);
        end
        @(negedge clk);
        tx_done = 1'b0;
        rx_done = 1'b0;
        if (!first) begin
            n_cmp++;
            if (busy !== 1'b0 || alu_valid !== 3'b000 || data_a !== exp_a) begin
                n_err++;
                $display("FAIL busy_after_done: got busy=%b vld=%b a=%h want busy=0 vld=000 a=%h",
                         busy, alu_valid, data_a, exp_a);
            end
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] lo, input logic [7:0] hi, input bit drop);
        send_byte(a, 3'b001);
        send_byte(b, 3'b010);
        exp_q.push_back(lo);
        exp_q.push_back(hi);
        send_byte(op, 3'b100);
        n_cmp++;
        if (busy !== 1'b1 || data_a !== a || data_b !== b || ops !== op[5:0]) begin
            n_err++;
            $display("FAIL operands op=%h: got busy=%b a=%h b=%h ops=%h want 1 %h %h %h",
                     op, busy, data_a, data_b, ops, a, b, op[5:0]);
        end
        tx_byte(1'b1, drop, a);
        tx_byte(1'b0, drop, a);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (data_a !== 8'h00 || data_b !== 8'h00 || ops !== 6'h00 || alu_valid !== 3'b000 ||
            tx_data !== 8'h00 || tx_start !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got a=%h b=%h op=%h vld=%b tx=%h st=%b busy=%b want all 0",
                     data_a, data_b, ops, alu_valid, tx_data, tx_start, busy);
        end
    endtask

    task automatic test_basic_ops;
        run_op(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 8'h20, 8'h00, 8'h01, 1'b0);
        run_op(8'h03, 8'h05, 8'h22, 8'hFE, 8'h00, 1'b0);
    endtask

    task automatic test_drop_rx;
        run_op(8'hF0, 8'h0F, 8'h25, 8'hFF, 8'h00, 1'b1);
    endtask

    task automatic test_tx_done_idle;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tx_done_idle: got start=%b busy=%b want 0 0", tx_start, busy);
        end
    endtask

    task automatic test_back_to_back;
        run_op(8'h02, 8'h02, 8'h24, 8'h02, 8'h00, 1'b0);
    endtask

    task automatic test_reset_abort;
        send_byte(8'h11, 3'b001);
        send_byte(8'h22, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h07, 3'b001);
        n_cmp++;
        if (data_a !== 8'h07 || data_b !== 8'h00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: got a=%h b=%h busy=%b want 07 00 0", data_a, data_b, busy);
        end
        send_byte(8'h01, 3'b010);
        n_cmp++;
        if (data_b !== 8'h01) begin
            n_err++;
            $display("FAIL reset_abort_wait_b: got b=%h want 01", data_b);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_drop_rx();
        test_tx_done_idle();
        test_back_to_back();
        test_reset_abort();
        n_cmp++;
        if (start_long !== 1'b0) begin
            n_err++;
            $display("FAIL tx_start_width: got multi-cycle pulse want single cycle");
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_tx: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
